prog_freq_divider: RTL and testbench

Runtime-programmable clock divider/tone generator, successor of the fixed-divisor divider. The period is loaded through a valid/ready port and applied only at period boundaries, so note changes never glitch. The output is an exact-duty square wave, a one-cycle period tick, and a graceful enable/stop. It drives the buzzer tone path (divisors up to 2^16) and the note-duration timebase (up to 2^22) from one design.

---
 rtl/divider_pkg.sv | 17 +
 rtl/prog_freq_divider.sv | 119 +++++++++++
 tb/tb_prog_freq_divider.sv | 298 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/divider_pkg.sv
// Shared types and helpers for the programmable frequency divider.
package divider_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_e;

  localparam int unsigned DIV_MUTE = 0;

  // High-phase length of a period of d cycles: ceil(d/2) without overflow.
  function automatic logic [31:0] half_period(input logic [31:0] d);
    return d - (d >> 1);
  endfunction

endpackage

// File: rtl/prog_freq_divider.sv
// Runtime-programmable divider: exact-duty square wave, period tick and
// glitch-free divisor updates applied only at period boundaries.
module prog_freq_divider
  import divider_pkg::*;
#(
  parameter int unsigned      WIDTH       = 22,
  parameter logic [WIDTH-1:0] DEFAULT_DIV = WIDTH'(12000)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] div_in,
  input  logic             div_valid,
  output logic             div_ready,
  output logic             clk_out,
  output logic             tick,
  output logic             active
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] cur_div_q, cur_div_d;
  logic [WIDTH-1:0] pend_div_q, pend_div_d;
  logic             pending_q, pending_d;
  logic             clk_out_q, clk_out_d;
  logic             tick_q, tick_d;
  logic             active_q, active_d;
  logic             div_ready_q, div_ready_d;

  logic             accept;
  logic             period_end;
  logic [WIDTH-1:0] half_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      cur_div_q   <= DEFAULT_DIV;
      pend_div_q  <= '0;
      pending_q   <= 1'b0;
      clk_out_q   <= 1'b0;
      tick_q      <= 1'b0;
      active_q    <= 1'b0;
      div_ready_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cur_div_q   <= cur_div_d;
      pend_div_q  <= pend_div_d;
      pending_q   <= pending_d;
      clk_out_q   <= clk_out_d;
      tick_q      <= tick_d;
      active_q    <= active_d;
      div_ready_q <= div_ready_d;
    end
  end

  assign accept     = div_valid && div_ready_q;
  assign period_end = (state_q != IDLE) && (cnt_q == cur_div_q - WIDTH'(1));

  // Next-state, divisor application and registered-output precompute.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    cur_div_d  = cur_div_q;
    pend_div_d = pend_div_q;
    pending_d  = pending_q;

    if (accept) begin
      pend_div_d = div_in;
      pending_d  = 1'b1;
    end

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (pending_q) begin
          cur_div_d = pend_div_q;
          pending_d = 1'b0;
        end
        if (en && (cur_div_d != WIDTH'(DIV_MUTE))) state_d = RUN;
      end
      RUN, DRAIN: begin
        if (period_end) begin
          cnt_d = '0;
          // A value accepted in the boundary cycle bypasses the pending slot.
          if (accept) begin
            cur_div_d = div_in;
            pending_d = 1'b0;
          end else if (pending_q) begin
            cur_div_d = pend_div_q;
            pending_d = 1'b0;
          end
          if (!en || (cur_div_d == WIDTH'(DIV_MUTE))) state_d = IDLE;
          else                                        state_d = RUN;
        end else begin
          cnt_d   = cnt_q + WIDTH'(1);
          state_d = en ? RUN : DRAIN;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    half_d      = WIDTH'(half_period(32'(cur_div_d)));
    active_d    = (state_d != IDLE);
    clk_out_d   = active_d && (cnt_d < half_d);
    tick_d      = active_d && (cnt_d == '0);
    div_ready_d = !pending_d;
  end

  assign div_ready = div_ready_q;
  assign clk_out   = clk_out_q;
  assign tick      = tick_q;
  assign active    = active_q;

endmodule

// File: tb/tb_prog_freq_divider.sv
// Self-checking bench for prog_freq_divider: vector table of divisors plus
// directed handshake, drain, mute and reset sequences.
module tb_prog_freq_divider;

  localparam int unsigned WIDTH = 22;
  localparam int unsigned DEF   = 12000;
  localparam int          BOUND = 20000;

  logic             clk = 1'b0;
  logic             rst;
  logic             en;
  logic [WIDTH-1:0] div_in;
  logic             div_valid;
  logic             div_ready;
  logic             clk_out;
  logic             tick;
  logic             active;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    int div;
    int high;
    int per;
  } vec_t;

  typedef struct {
    int high;
    int per;
  } exp_t;

  exp_t exp_q[$];
  vec_t vecs[8];

  always #5 clk = ~clk;

  prog_freq_divider #(
    .WIDTH      (WIDTH),
    .DEFAULT_DIV(WIDTH'(DEF))
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .div_in   (div_in),
    .div_valid(div_valid),
    .div_ready(div_ready),
    .clk_out  (clk_out),
    .tick     (tick),
    .active   (active)
  );

  task automatic check(input string name, input int got, input int want);
    n_checks++;
    if (got != want) begin
      n_errors++;
      $display("FAIL %s: got %0d, want %0d", name, got, want);
    end
  endtask

  task automatic nxt();
    @(negedge clk);
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push_exp(input int high, input int per);
    exp_t e;
    e.high = high;
    e.per  = per;
    exp_q.push_back(e);
  endtask

  // Cycles from the current sample until a tick is seen; -1 if the bound expires.
  task automatic wait_tick(output int n);
    n = 0;
    while (tick !== 1'b1 && n < BOUND) begin
      nxt();
      n++;
    end
    if (tick !== 1'b1) n = -1;
  endtask

  // Measure one full period from the next tick and compare with the queued expectation.
  task automatic measure(input string name);
    int   n;
    int   hi;
    int   per;
    exp_t e;
    hi  = 0;
    per = 0;
    wait_tick(n);
    if (n >= 0) begin
      do begin
        per++;
        if (clk_out === 1'b1) hi++;
        nxt();
      end while (tick !== 1'b1 && per < BOUND);
    end
    if (exp_q.size() == 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL %s: no expectation queued", name);
    end else begin
      e = exp_q.pop_front();
      check({name, " high"}, hi, e.high);
      check({name, " period"}, per, e.per);
    end
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    en        = 1'b0;
    div_valid = 1'b0;
    div_in    = '0;
    step(2);
    rst = 1'b0;
    nxt();
  endtask

  // Load d while idle, then raise en; returns at the first tick (cnt=0).
  task automatic setup_run(input int d);
    do_reset();
    div_in    = WIDTH'(d);
    div_valid = 1'b1;
    nxt();
    div_valid = 1'b0;
    en        = 1'b1;
    nxt();
  endtask

  initial begin
    int n;
    int hi;
    int tk;
    int act;

    vecs[0] = '{div: 1,  high: 1, per: 1};
    vecs[1] = '{div: 2,  high: 1, per: 2};
    vecs[2] = '{div: 3,  high: 2, per: 3};
    vecs[3] = '{div: 4,  high: 2, per: 4};
    vecs[4] = '{div: 5,  high: 3, per: 5};
    vecs[5] = '{div: 7,  high: 4, per: 7};
    vecs[6] = '{div: 10, high: 5, per: 10};
    vecs[7] = '{div: 16, high: 8, per: 16};

    // Reset values, then default divisor
    rst       = 1'b1;
    en        = 1'b0;
    div_valid = 1'b0;
    div_in    = '0;
    #1;
    check("reset clk_out", int'(clk_out), 0);
    check("reset tick", int'(tick), 0);
    check("reset active", int'(active), 0);
    check("reset div_ready", int'(div_ready), 1);
    step(2);
    rst = 1'b0;
    nxt();
    en = 1'b1;
    nxt();
    check("default first tick", int'(tick), 1);
    check("default first clk_out", int'(clk_out), 1);
    check("default active", int'(active), 1);
    push_exp(6000, 12000);
    measure("default");

    // Divisor table
    for (int i = 0; i < 8; i++) begin
      setup_run(vecs[i].div);
      check($sformatf("vec%0d first tick", i), int'(tick), 1);
      push_exp(vecs[i].high, vecs[i].per);
      measure($sformatf("vec%0d D=%0d", i, vecs[i].div));
    end

    // Mid-period load of 7 while running at 10
    setup_run(10);
    step(3);
    div_in    = WIDTH'(7);
    div_valid = 1'b1;
    nxt();
    check("load7 ready low", int'(div_ready), 0);
    div_valid = 1'b0;
    wait_tick(n);
    check("load7 old period remainder", n, 6);
    check("load7 ready after boundary", int'(div_ready), 1);
    push_exp(4, 7);
    measure("load7");

    // Load accepted in the boundary cycle
    setup_run(8);
    step(7);
    check("bypass ready at end", int'(div_ready), 1);
    div_in    = WIDTH'(5);
    div_valid = 1'b1;
    nxt();
    div_valid = 1'b0;
    check("bypass tick", int'(tick), 1);
    check("bypass ready stays", int'(div_ready), 1);
    push_exp(3, 5);
    measure("bypass5");

    // en drop and re-raise within a period
    setup_run(8);
    step(2);
    en = 1'b0;
    nxt();
    check("drain active", int'(active), 1);
    step(2);
    en = 1'b1;
    wait_tick(n);
    check("drain rejoin gap", n, 3);
    push_exp(4, 8);
    measure("drain rejoin");

    // en drop, not re-raised
    setup_run(8);
    step(2);
    en = 1'b0;
    n  = 0;
    while (active === 1'b1 && n < BOUND) begin
      nxt();
      n++;
    end
    check("drain stop cycles", n, 6);
    check("drain stop clk_out", int'(clk_out), 0);

    // Mute, then D=1
    setup_run(4);
    div_in    = '0;
    div_valid = 1'b1;
    nxt();
    check("mute ready low", int'(div_ready), 0);
    div_valid = 1'b0;
    n = 0;
    while (active === 1'b1 && n < BOUND) begin
      nxt();
      n++;
    end
    check("mute finish cycles", n, 3);
    check("mute clk_out", int'(clk_out), 0);
    tk  = 0;
    act = 0;
    for (int i = 0; i < 20; i++) begin
      nxt();
      tk  += int'(tick);
      act += int'(active);
    end
    check("mute ticks", tk, 0);
    check("mute active", act, 0);
    div_in    = WIDTH'(1);
    div_valid = 1'b1;
    nxt();
    check("d1 ready low", int'(div_ready), 0);
    div_valid = 1'b0;
    nxt();
    check("d1 first tick", int'(tick), 1);
    check("d1 first clk_out", int'(clk_out), 1);
    hi = 0;
    tk = 0;
    for (int i = 0; i < 10; i++) begin
      nxt();
      hi += int'(clk_out);
      tk += int'(tick);
    end
    check("d1 clk_out high", hi, 10);
    check("d1 ticks", tk, 10);

    // Reset mid-period with a pending load
    setup_run(6);
    nxt();
    div_in    = WIDTH'(9);
    div_valid = 1'b1;
    nxt();
    div_valid = 1'b0;
    check("rst pending ready low", int'(div_ready), 0);
    nxt();
    check("rst pre active", int'(active), 1);
    rst = 1'b1;
    #1;
    check("rst mid clk_out", int'(clk_out), 0);
    check("rst mid tick", int'(tick), 0);
    check("rst mid active", int'(active), 0);
    check("rst mid div_ready", int'(div_ready), 1);
    nxt();
    rst = 1'b0;
    nxt();
    check("rst release tick", int'(tick), 1);
    push_exp(6000, 12000);
    measure("after reset");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
